// File: rtl/spike_scheduler_if.sv
// -----------------------------------------------------------------------------
// spike_scheduler_if
// Bundles the two handshakes of the spike scheduler:
//   - router side : spike_in_valid / spike_in_ready with axon index and delay
//   - controller  : scheduler_read_request / scheduler_clear_request, and the
//                   returned axon_activity / activity_valid
// modport slave  : used by spike_scheduler
// modport master : used by the router / token_controller side
// -----------------------------------------------------------------------------
interface spike_scheduler_if #(
    parameter int NUM_AXONS = 256,
    parameter int AXON_W    = 8,
    parameter int TICK_W    = 4
);
    logic                 spike_in_valid;
    logic                 spike_in_ready;
    logic [AXON_W-1:0]    spike_in_axon;
    logic [TICK_W-1:0]    spike_in_delay;
    logic                 scheduler_read_request;
    logic                 scheduler_clear_request;
    logic [NUM_AXONS-1:0] axon_activity;
    logic                 activity_valid;

    modport slave (
        input  spike_in_valid, spike_in_axon, spike_in_delay,
        input  scheduler_read_request, scheduler_clear_request,
        output spike_in_ready, axon_activity, activity_valid
    );

    modport master (
        output spike_in_valid, spike_in_axon, spike_in_delay,
        output scheduler_read_request, scheduler_clear_request,
        input  spike_in_ready, axon_activity, activity_valid
    );
endinterface

// File: rtl/spike_scheduler.sv
// -----------------------------------------------------------------------------
// spike_scheduler
// Per-core axon delay buffer feeding token_controller. NUM_SLOTS circular tick
// slots of NUM_AXONS bits each. Spikes from the router set one bit in the slot
// (current_slot + delay); the controller reads the current slot, then clears it.
// Each tick advances the slot pointer (deferred while a read/clear is active).
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous active-low reset
//   tick         global tick pulse (one clk wide)
//   bus          spike_scheduler_if.slave: spike handshake, read/clear
//                requests, axon_activity / activity_valid
//   current_slot slot pointer
//   busy         FSM not idle
//   spike_drop   one-cycle pulse: illegal spike discarded
//   tick_overrun one-cycle pulse: tick arrived while one was already pending
//
// Optional build macro SPIKE_SCHEDULER_STATS_EN adds saturating 16-bit
// counters stat_accepted (legal spikes stored) and stat_dropped (drops).
// -----------------------------------------------------------------------------
module spike_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_SLOTS = 16,
    parameter int AXON_W    = 8,
    parameter int TICK_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    spike_scheduler_if.slave     bus,
    output logic [TICK_W-1:0]    current_slot,
    output logic                 busy,
    output logic                 spike_drop,
    output logic                 tick_overrun
`ifdef SPIKE_SCHEDULER_STATS_EN
    ,
    output logic [15:0]          stat_accepted,
    output logic [15:0]          stat_dropped
`endif
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, CLEAR} state_t;

    localparam logic [TICK_W-1:0] PTR_ONE = TICK_W'(1);

    state_t               state_reg, state_next;
    logic [TICK_W-1:0]    slot_ptr_reg, slot_ptr_next;
    logic                 pending_reg, pending_next;
    logic                 overrun_reg, overrun_next;
    logic                 drop_reg;
    logic [NUM_AXONS-1:0] activity_reg;
    logic                 activity_valid_reg;

    // Read view of the slot storage; each row is owned by its own generate block.
    logic [NUM_AXONS-1:0] slot_view [NUM_SLOTS];

    // Spike acceptance
    logic                 ready_int;
    logic                 spike_fire;
    logic                 axon_bad;
    logic                 spike_illegal;
    logic                 spike_write;
    logic [TICK_W-1:0]    target_slot;
    logic                 clear_slot;

    // Ready is forced low while reset is asserted, not just after it.
    assign ready_int     = rst && (state_reg != CLEAR);
    assign spike_fire    = bus.spike_in_valid && ready_int;
    assign axon_bad      = int'(bus.spike_in_axon) >= NUM_AXONS;
    assign spike_illegal = (bus.spike_in_delay == '0) || axon_bad;
    assign spike_write   = spike_fire && !spike_illegal;
    // Pointer arithmetic wraps naturally since NUM_SLOTS == 2**TICK_W.
    assign target_slot   = slot_ptr_reg + bus.spike_in_delay;
    assign clear_slot    = (state_reg == CLEAR);

    // -------------------------------------------------------------------------
    // FSM next-state and tick bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        slot_ptr_next = slot_ptr_reg;
        pending_next  = pending_reg;
        overrun_next  = tick && pending_reg;
        case (state_reg)
            IDLE: begin
                if (bus.scheduler_read_request) begin
                    state_next = READ;
                    // A tick racing a read must not move the slot under it.
                    if (tick) begin
                        pending_next = 1'b1;
                    end
                end else if (tick) begin
                    slot_ptr_next = slot_ptr_reg + PTR_ONE;
                end
            end
            READ: begin
                state_next = HOLD;
                if (tick) begin
                    pending_next = 1'b1;
                end
            end
            HOLD: begin
                if (bus.scheduler_clear_request) begin
                    state_next = CLEAR;
                end
                if (tick) begin
                    pending_next = 1'b1;
                end
            end
            CLEAR: begin
                state_next = IDLE;
                // Deferred tick (or one arriving right now) is applied on the
                // way back to IDLE, so IDLE never sees pending set.
                if (pending_reg || tick) begin
                    slot_ptr_next = slot_ptr_reg + PTR_ONE;
                    pending_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            slot_ptr_reg       <= '0;
            pending_reg        <= 1'b0;
            overrun_reg        <= 1'b0;
            drop_reg           <= 1'b0;
            activity_reg       <= '0;
            activity_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_ptr_reg <= slot_ptr_next;
            pending_reg  <= pending_next;
            overrun_reg  <= overrun_next;
            drop_reg     <= spike_fire && spike_illegal;
            if (state_reg == READ) begin
                // Data and valid land together when HOLD is entered.
                activity_reg       <= slot_view[slot_ptr_reg];
                activity_valid_reg <= 1'b1;
            end else if (state_reg == CLEAR) begin
                // axon_activity deliberately keeps its last value.
                activity_valid_reg <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slot storage. Clear and write never collide: ready is low in CLEAR, and
    // a legal delay never targets the slot under the pointer.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [NUM_AXONS-1:0] row_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    row_reg <= '0;
                end else if (clear_slot && (slot_ptr_reg == TICK_W'(gi))) begin
                    row_reg <= '0;
                end else if (spike_write && (target_slot == TICK_W'(gi))) begin
                    row_reg[bus.spike_in_axon] <= 1'b1;
                end
            end

            assign slot_view[gi] = row_reg;
        end
    endgenerate

`ifdef SPIKE_SCHEDULER_STATS_EN
    logic [15:0] acc_cnt_reg;
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (spike_write && (acc_cnt_reg != 16'hFFFF)) begin
                acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
            if (spike_fire && spike_illegal && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign stat_accepted = acc_cnt_reg;
    assign stat_dropped  = drop_cnt_reg;
`endif

    assign bus.spike_in_ready = ready_int;
    assign bus.axon_activity  = activity_reg;
    assign bus.activity_valid = activity_valid_reg;
    assign current_slot       = slot_ptr_reg;
    assign busy               = (state_reg != IDLE);
    assign spike_drop         = drop_reg;
    assign tick_overrun       = overrun_reg;

endmodule
